seq_and_stim_gen: RTL and testbench

//  Programmable stimulus generator driving the two-input AND sequence checker.

---
 rtl/seq_and_stim_gen.sv | 125 ++++++++++++
 tb/tb_seq_and_stim_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_and_stim_gen.sv
// Stimulus generator for the two-input AND sequence checker: one programmable window per signal.
// Optional self-check of the checker's match output is enabled with `define SEQ_AND_CHECK_EN.
module seq_and_stim_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] dly_1,
  input  logic [CNT_W-1:0] len_1,
  input  logic [CNT_W-1:0] dly_2,
  input  logic [CNT_W-1:0] len_2,
  output logic             busy,
  output logic             done,
  output logic             chk_en,
  output logic             signal_1,
  output logic             signal_2,
  output logic             overlap
`ifdef SEQ_AND_CHECK_EN
  ,
  input  logic             match_in,
  output logic             err
`endif
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_e;

  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

  state_e           state_q, state_d;
  logic [CNT_W:0]   t_q, t_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] dly_1_q, len_1_q, dly_2_q, len_2_q;
  logic [CNT_W:0]   end_1, end_2, total;
  logic             s1, s2;
  logic             accept;

  assign accept = (state_q == IDLE) && start;

  // Window ends are computed one bit wider so 255+255 does not wrap.
  assign end_1 = {1'b0, dly_1_q} + {1'b0, len_1_q};
  assign end_2 = {1'b0, dly_2_q} + {1'b0, len_2_q};
  assign total = (end_1 > end_2) ? end_1 : end_2;

  assign s1 = (state_q == RUN) && (t_q >= {1'b0, dly_1_q}) && (t_q < end_1);
  assign s2 = (state_q == RUN) && (t_q >= {1'b0, dly_2_q}) && (t_q < end_2);

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign chk_en   = (state_q == PRIME);
  assign signal_1 = s1;
  assign signal_2 = s2;
  assign overlap  = ovl_q;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    ovl_d   = ovl_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PRIME;
          ovl_d   = 1'b0;
        end
      end
      PRIME: begin
        t_d     = '0;
        state_d = (total == '0) ? DONE : RUN;
      end
      RUN: begin
        if (s1 && s2) ovl_d = 1'b1;
        if (t_q == total - ONE) state_d = DONE;
        else                    t_d     = t_q + ONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      ovl_q   <= ovl_d;
    end
  end

  // Run parameters are captured once per accepted start; inputs are free afterwards.
  always_ff @(posedge clk) begin
    if (accept) begin
      dly_1_q <= dly_1;
      len_1_q <= len_1;
      dly_2_q <= dly_2;
      len_2_q <= len_2;
    end
  end

`ifdef SEQ_AND_CHECK_EN
  logic exp_q, err_q;

  // exp mirrors the checker's hold behaviour: set on both-high, clear on both-low.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state_q == PRIME)  exp_q <= 1'b0;
      else if (s1 && s2)     exp_q <= 1'b1;
      else if (!s1 && !s2)   exp_q <= 1'b0;

      if (accept)
        err_q <= 1'b0;
      else if (((state_q == RUN) || (state_q == DONE)) && (match_in != exp_q))
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_seq_and_stim_gen.sv
// Directed bench for seq_and_stim_gen: relative-time model checked every cycle plus literal checks.
// Extra error-flag checks are built when SEQ_AND_CHECK_EN is defined.
module tb_seq_and_stim_gen;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [CNT_W-1:0] dly_1, len_1, dly_2, len_2;
  logic             busy, done, chk_en, signal_1, signal_2, overlap;
`ifdef SEQ_AND_CHECK_EN
  logic             match_in, err, force_on, chk_q;
`endif

  seq_and_stim_gen #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dly_1(dly_1), .len_1(len_1), .dly_2(dly_2), .len_2(len_2),
    .busy(busy), .done(done), .chk_en(chk_en),
    .signal_1(signal_1), .signal_2(signal_2), .overlap(overlap)
`ifdef SEQ_AND_CHECK_EN
    , .match_in(match_in), .err(err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_on = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit win(input int t, input int d, input int l);
    return (t >= d) && (t < d + l);
  endfunction

  // Model: a run is described only by how many cycles have passed since its accepted start.
  bit m_act = 0;
  bit m_ovl = 0;
  int m_rel, md1, ml1, md2, ml2, mT, m_t;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_act = 0;
      m_ovl = 0;
    end else if (m_act) begin
      m_t = m_rel - 2;
      if (m_t >= 0 && m_t < mT && win(m_t, md1, ml1) && win(m_t, md2, ml2)) m_ovl = 1;
      m_rel++;
      if (m_rel > mT + 2) m_act = 0;
    end else if (start) begin
      m_act = 1;
      m_rel = 1;
      md1 = dly_1; ml1 = len_1; md2 = dly_2; ml2 = len_2;
      mT  = (md1 + ml1 > md2 + ml2) ? md1 + ml1 : md2 + ml2;
      m_ovl = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      bit run;
      int t;
      t   = m_rel - 2;
      run = m_act && (t >= 0) && (t < mT);
      chk("busy",     busy,     m_act);
      chk("chk_en",   chk_en,   m_act && m_rel == 1);
      chk("done",     done,     m_act && m_rel == mT + 2);
      chk("signal_1", signal_1, run && win(t, md1, ml1));
      chk("signal_2", signal_2, run && win(t, md2, ml2));
      chk("overlap",  overlap,  m_ovl);
    end
  end

`ifdef SEQ_AND_CHECK_EN
  // Reference AND checker: match follows both-high / both-low, holds otherwise.
  always @(posedge clk) begin
    if (chk_en)                    chk_q <= 1'b0;
    else if (signal_1 && signal_2) chk_q <= 1'b1;
    else if (!signal_1 && !signal_2) chk_q <= 1'b0;
  end
  assign match_in = force_on ? 1'b0 : chk_q;
`endif

  // Starts a run, then returns at the DONE cycle's negedge with the start-to-done latency.
  task automatic run_case(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d,
                          output int lat, output logic ov);
    @(posedge clk); #1;
    dly_1 = a; len_1 = b; dly_2 = c; len_2 = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dly_1 = 8'hA5; len_1 = 8'h5A; dly_2 = 8'h3C; len_2 = 8'hC3;
    lat = 0;
    ov  = 1'bx;
    while (lat < 2000) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    if (lat >= 2000) begin
      errors++;
      $display("FAIL run_timeout: got no done within %0d cycles", lat);
    end
    ov = overlap;
  endtask

  int   lat, n, dn;
  logic ov;

  initial begin
`ifdef SEQ_AND_CHECK_EN
    force_on = 1'b0;
    chk_q    = 1'b0;
`endif
    rst = 1'b1; start = 1'b0;
    dly_1 = '0; len_1 = '0; dly_2 = '0; len_2 = '0;
    @(posedge clk); #1;
    cmp_on = 1;
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_overlap", overlap, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-run at t=3 of a 0/8 window.
    @(posedge clk); #1;
    dly_1 = 8'd0; len_1 = 8'd8; dly_2 = 8'd0; len_2 = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrun_sig1_before_rst", signal_1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrun_busy_after_rst", busy, 1'b0);
    chk("midrun_sig1_after_rst", signal_1, 1'b0);

    run_case(8'd0, 8'd3, 8'd1, 8'd2, lat, ov);
    chk_int("fresh_after_rst_latency", lat, 5);
    chk("fresh_after_rst_overlap", ov, 1'b1);

    run_case(8'd1, 8'd4, 8'd2, 8'd4, lat, ov);
    chk_int("basic_latency", lat, 8);
    chk("basic_overlap", ov, 1'b1);

    run_case(8'd0, 8'd2, 8'd5, 8'd1, lat, ov);
    chk_int("disjoint_latency", lat, 8);
    chk("disjoint_overlap", ov, 1'b0);

    run_case(8'd7, 8'd0, 8'd9, 8'd0, lat, ov);
    chk_int("zero_len_latency", lat, 11);

    run_case(8'd0, 8'd0, 8'd0, 8'd0, lat, ov);
    chk_int("zero_total_latency", lat, 2);
    chk("zero_total_overlap", ov, 1'b0);

    // Longest run plus an ignored start in the middle of RUN.
    @(posedge clk); #1;
    dly_1 = 8'd255; len_1 = 8'd255; dly_2 = 8'd255; len_2 = 8'd255; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; dn = 0; lat = -1;
    while (n < 600) begin
      @(negedge clk);
      n++;
      if (done) begin
        dn++;
        if (lat < 0) lat = n;
      end
      if (n == 100) start = 1'b1;
      if (n == 101) start = 1'b0;
    end
    chk_int("max_latency", lat, 512);
    chk_int("max_done_pulses", dn, 1);

`ifdef SEQ_AND_CHECK_EN
    run_case(8'd1, 8'd4, 8'd2, 8'd4, lat, ov);
    chk("err_conforming", err, 1'b0);

    @(posedge clk); #1;
    dly_1 = 8'd1; len_1 = 8'd4; dly_2 = 8'd2; len_2 = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(signal_1 && signal_2) && n < 50);
    @(posedge clk); #1;
    force_on = 1'b1;
    @(posedge clk); #1;
    force_on = 1'b0;
    @(negedge clk);
    chk("err_set", err, 1'b1);
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("err_sticky_done", err, 1'b1);
    run_case(8'd0, 8'd1, 8'd0, 8'd1, lat, ov);
    chk("err_cleared_by_start", err, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
